// File: rtl/router_fifo.sv
// Per-destination output FIFO of the 1x3 router: stores header-tagged bytes and tracks packet boundaries on read.
// Optional build macro ROUTER_FIFO_OCC_EN adds the occupancy output port.
module router_fifo #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              soft_reset,
  input  logic              write_enb,
  input  logic              read_enb,
  input  logic              lfd_state,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              full,
  output logic              empty,
  output logic              pkt_done
`ifdef ROUTER_FIFO_OCC_EN
  ,
  output logic [ADDR_W:0]   occupancy
`endif
);

  localparam int CNT_W = DATA_W - 1;
  localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  logic [DATA_W:0]   mem_r [DEPTH];
  logic [ADDR_W:0]   wr_ptr_r;
  logic [ADDR_W:0]   rd_ptr_r;
  logic [CNT_W-1:0]  pkt_cnt_r;
  logic [DATA_W-1:0] data_out_r;
  logic              pkt_done_r;

  logic [ADDR_W:0]   wr_ptr_nxt_s;
  logic [ADDR_W:0]   rd_ptr_nxt_s;
  logic [CNT_W-1:0]  pkt_cnt_nxt_s;
  logic [DATA_W-1:0] data_out_nxt_s;
  logic              pkt_done_nxt_s;
  logic              wr_en_s;
  logic              rd_en_s;
  logic [DATA_W:0]   rd_word_s;

  assign empty = (wr_ptr_r == rd_ptr_r);
  assign full  = (wr_ptr_r[ADDR_W-1:0] == rd_ptr_r[ADDR_W-1:0]) &&
                 (wr_ptr_r[ADDR_W] != rd_ptr_r[ADDR_W]);

  // Any reset cycle swallows the request, so accesses only qualify when neither reset is active.
  assign wr_en_s   = resetn && !soft_reset && write_enb && !full;
  assign rd_en_s   = resetn && !soft_reset && read_enb && !empty;
  assign rd_word_s = mem_r[rd_ptr_r[ADDR_W-1:0]];

  assign data_out = data_out_r;
  assign pkt_done = pkt_done_r;

`ifdef ROUTER_FIFO_OCC_EN
  assign occupancy = wr_ptr_r - rd_ptr_r;
`endif

  // Storage write; contents deliberately survive both resets.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r[ADDR_W-1:0]] <= {lfd_state, data_in};
    end
  end

  // Next-state for pointers, read data and packet tracking.
  always_comb begin
    wr_ptr_nxt_s   = wr_ptr_r;
    rd_ptr_nxt_s   = rd_ptr_r;
    pkt_cnt_nxt_s  = pkt_cnt_r;
    data_out_nxt_s = data_out_r;
    pkt_done_nxt_s = 1'b0;

    if (wr_en_s) begin
      wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
    end else begin
      wr_ptr_nxt_s = wr_ptr_r;
    end

    if (rd_en_s) begin
      rd_ptr_nxt_s   = rd_ptr_r + PTR_ONE;
      data_out_nxt_s = rd_word_s[DATA_W-1:0];
      if (rd_word_s[DATA_W]) begin
        // Header: payload length plus the trailing parity byte; abandons any truncated packet.
        pkt_cnt_nxt_s = {1'b0, rd_word_s[DATA_W-1:2]} + CNT_ONE;
      end else if (pkt_cnt_r != CNT_ZERO) begin
        pkt_cnt_nxt_s  = pkt_cnt_r - CNT_ONE;
        pkt_done_nxt_s = (pkt_cnt_r == CNT_ONE);
      end else begin
        pkt_cnt_nxt_s = CNT_ZERO;
      end
    end else begin
      rd_ptr_nxt_s   = rd_ptr_r;
      data_out_nxt_s = data_out_r;
    end
  end

  // State registers; resetn takes priority over the soft flush.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_r   <= {(ADDR_W+1){1'b0}};
      rd_ptr_r   <= {(ADDR_W+1){1'b0}};
      pkt_cnt_r  <= CNT_ZERO;
      data_out_r <= {DATA_W{1'b0}};
      pkt_done_r <= 1'b0;
    end else if (soft_reset) begin
      wr_ptr_r   <= {(ADDR_W+1){1'b0}};
      rd_ptr_r   <= {(ADDR_W+1){1'b0}};
      pkt_cnt_r  <= CNT_ZERO;
      data_out_r <= {DATA_W{1'b0}};
      pkt_done_r <= 1'b0;
    end else begin
      wr_ptr_r   <= wr_ptr_nxt_s;
      rd_ptr_r   <= rd_ptr_nxt_s;
      pkt_cnt_r  <= pkt_cnt_nxt_s;
      data_out_r <= data_out_nxt_s;
      pkt_done_r <= pkt_done_nxt_s;
    end
  end

endmodule

// File: tb/tb_router_fifo.sv
// Directed self-checking bench for router_fifo; expected values are hand-computed constants.
module tb_router_fifo;

  logic       clk;
  logic       resetn;
  logic       soft_reset;
  logic       write_enb;
  logic       read_enb;
  logic       lfd_state;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       full;
  logic       empty;
  logic       pkt_done;
`ifdef ROUTER_FIFO_OCC_EN
  logic [4:0] occupancy;
`endif

  int n_cmp = 0;
  int n_err = 0;

  router_fifo #(.DATA_W(8), .ADDR_W(4), .DEPTH(16)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .soft_reset (soft_reset),
    .write_enb  (write_enb),
    .read_enb   (read_enb),
    .lfd_state  (lfd_state),
    .data_in    (data_in),
    .data_out   (data_out),
    .full       (full),
    .empty      (empty),
    .pkt_done   (pkt_done)
`ifdef ROUTER_FIFO_OCC_EN
    ,
    .occupancy  (occupancy)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic hdr, input logic [7:0] d);
    write_enb = 1'b1;
    lfd_state = hdr;
    data_in   = d;
    tick();
    write_enb = 1'b0;
    lfd_state = 1'b0;
  endtask

  task automatic do_read(input string tag, input logic [7:0] exp_d, input logic exp_done);
    read_enb = 1'b1;
    tick();
    read_enb = 1'b0;
    check_value(tag, 32'(data_out), 32'(exp_d));
    check_value({tag, "_done"}, 32'(pkt_done), 32'(exp_done));
  endtask

  initial begin
    logic [7:0] exp_q[$];
    logic [7:0] pkt2 [5];
    pkt2 = '{8'h0C, 8'hA1, 8'hA2, 8'hA3, 8'h5E};

    resetn = 1'b0; soft_reset = 1'b0; write_enb = 1'b0; read_enb = 1'b0;
    lfd_state = 1'b0; data_in = 8'h00;

    // 1: reset state
    tick(); tick();
    check_value("rst_empty", 32'(empty), 32'd1);
    check_value("rst_full", 32'(full), 32'd0);
    check_value("rst_data", 32'(data_out), 32'd0);
    check_value("rst_done", 32'(pkt_done), 32'd0);
    resetn = 1'b1;
    tick();

    // 2: one packet, pkt_done only with the parity byte
    for (int i = 0; i < 5; i++) do_write(i == 0, pkt2[i]);
    check_value("p2_empty_pre", 32'(empty), 32'd0);
    for (int i = 0; i < 5; i++) do_read("p2_rd", pkt2[i], i == 4);
    check_value("p2_empty", 32'(empty), 32'd1);
    tick();
    check_value("p2_done_clr", 32'(pkt_done), 32'd0);

    // 3: fill to full, overflow write dropped, drain in order
    for (int i = 0; i < 16; i++) do_write(1'b0, 8'h10 + 8'(i));
    check_value("p3_full", 32'(full), 32'd1);
    check_value("p3_notempty", 32'(empty), 32'd0);
`ifdef ROUTER_FIFO_OCC_EN
    check_value("p3_occ", 32'(occupancy), 32'd16);
`endif
    do_write(1'b0, 8'hFF);
    check_value("p3_full_ovf", 32'(full), 32'd1);
    for (int i = 0; i < 16; i++) do_read("p3_rd", 8'h10 + 8'(i), 1'b0);
    check_value("p3_empty", 32'(empty), 32'd1);
    check_value("p3_notfull", 32'(full), 32'd0);

    // 4: hold 8 words, 20 cycles of simultaneous read+write across the wrap
    for (int i = 0; i < 8; i++) begin
      do_write(1'b0, 8'h40 + 8'(i));
      exp_q.push_back(8'h40 + 8'(i));
    end
    for (int k = 0; k < 20; k++) begin
      write_enb = 1'b1;
      read_enb  = 1'b1;
      data_in   = 8'h50 + 8'(k);
      exp_q.push_back(8'h50 + 8'(k));
      tick();
      check_value("p4_data", 32'(data_out), 32'(exp_q.pop_front()));
      check_value("p4_full", 32'(full), 32'd0);
      check_value("p4_empty", 32'(empty), 32'd0);
`ifdef ROUTER_FIFO_OCC_EN
      check_value("p4_occ", 32'(occupancy), 32'd8);
`endif
    end
    write_enb = 1'b0;
    read_enb  = 1'b0;
    while (exp_q.size() > 0) do_read("p4_drain", exp_q.pop_front(), 1'b0);
    check_value("p4_empty_end", 32'(empty), 32'd1);

    // 5: soft_reset mid-packet, then a zero-length packet
    do_write(1'b1, 8'h14);
    for (int i = 0; i < 5; i++) do_write(1'b0, 8'hB1 + 8'(i));
    do_write(1'b0, 8'hC7);
    do_read("p5_hdr", 8'h14, 1'b0);
    do_read("p5_b1", 8'hB1, 1'b0);
    do_read("p5_b2", 8'hB2, 1'b0);
    soft_reset = 1'b1;
    tick();
    soft_reset = 1'b0;
    check_value("p5_sr_empty", 32'(empty), 32'd1);
    check_value("p5_sr_data", 32'(data_out), 32'd0);
    check_value("p5_sr_done", 32'(pkt_done), 32'd0);
    tick();
    check_value("p5_sr_done2", 32'(pkt_done), 32'd0);
    do_write(1'b1, 8'h02);
    do_write(1'b0, 8'h9A);
    do_read("p5_new_hdr", 8'h02, 1'b0);
    do_read("p5_new_par", 8'h9A, 1'b1);
    check_value("p5_new_empty", 32'(empty), 32'd1);

    // Truncated packet abandoned by a new header
    do_write(1'b1, 8'h08);
    do_write(1'b0, 8'h11);
    do_write(1'b1, 8'h06);
    do_write(1'b0, 8'h22);
    do_write(1'b0, 8'h33);
    do_read("tr_hdr1", 8'h08, 1'b0);
    do_read("tr_p1", 8'h11, 1'b0);
    do_read("tr_hdr2", 8'h06, 1'b0);
    do_read("tr_p2", 8'h22, 1'b0);
    do_read("tr_par", 8'h33, 1'b1);

    // 6: read on empty holds data_out and pointers
    do_write(1'b0, 8'h3C);
    do_read("p6_ld", 8'h3C, 1'b0);
    read_enb = 1'b1;
    tick(); tick();
    read_enb = 1'b0;
    check_value("p6_hold", 32'(data_out), 32'h3C);
    check_value("p6_empty", 32'(empty), 32'd1);
    check_value("p6_done", 32'(pkt_done), 32'd0);
`ifdef ROUTER_FIFO_OCC_EN
    check_value("p6_occ", 32'(occupancy), 32'd0);
`endif
    do_write(1'b0, 8'h55);
    do_read("p6_next", 8'h55, 1'b0);
    check_value("p6_empty_end", 32'(empty), 32'd1);

    // resetn wins over a concurrent write
    resetn    = 1'b0;
    write_enb = 1'b1;
    data_in   = 8'h77;
    tick();
    write_enb = 1'b0;
    resetn    = 1'b1;
    check_value("hr_empty", 32'(empty), 32'd1);
    check_value("hr_data", 32'(data_out), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
